// File: rtl/branch_predictor_pkg.sv
// Shared branch-predictor types: counter encodings, BTB entry, helpers.
package branch_predictor_pkg;

  localparam int BP_DEFAULT_ENTRIES = 64;
  localparam int BP_TAG_W = 30;

  typedef enum logic [1:0] {
    BP_SNT = 2'd0,
    BP_WNT = 2'd1,
    BP_WT  = 2'd2,
    BP_ST  = 2'd3
  } bp_ctr_e;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
    logic                uncond;
    bp_ctr_e             ctr;
  } bp_entry_t;

  localparam bp_entry_t BP_RST_ENTRY = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    uncond: 1'b0,
    ctr:    BP_WNT
  };

  function automatic bp_ctr_e bp_sat_inc(input bp_ctr_e c);
    return (c == BP_ST) ? BP_ST : bp_ctr_e'(c + 2'd1);
  endfunction

  function automatic bp_ctr_e bp_sat_dec(input bp_ctr_e c);
    return (c == BP_SNT) ? BP_SNT : bp_ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bpred_btb.sv
// BTB entry storage: two async read ports (fetch, execute),
// one sync write port, async active-high reset.
module bpred_btb
  import branch_predictor_pkg::*;
#(
  parameter  int ENTRIES = BP_DEFAULT_ENTRIES,
  localparam int IDX     = $clog2(ENTRIES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IDX-1:0] rd0_idx,
  output bp_entry_t      rd0_ent,
  input  logic [IDX-1:0] rd1_idx,
  output bp_entry_t      rd1_ent,
  input  logic           we,
  input  logic [IDX-1:0] wr_idx,
  input  bp_entry_t      wr_ent
);

  bp_entry_t tbl_q [ENTRIES];
  bp_entry_t tbl_d [ENTRIES];

  always_comb begin
    tbl_d = tbl_q;
    if (we) tbl_d[wr_idx] = wr_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl_q[i] <= BP_RST_ENTRY;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign rd0_ent = tbl_q[rd0_idx];
  assign rd1_ent = tbl_q[rd1_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side BTB predictor with Execute-stage mispredict check and training.
// Optional statistics counters enabled by BPRED_STATS_EN.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_ENTRIES = BP_DEFAULT_ENTRIES
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] FetchPC,
  output logic        PredTaken,
  output logic [31:0] PredTarget,
  input  logic        ExValid,
  input  logic        ExIsCtrl,
  input  logic        ExIsUncond,
  input  logic [31:0] ExPC,
  input  logic        ExJumpFlag,
  input  logic [31:0] ExTarget,
  input  logic        ExPredTaken,
  input  logic [31:0] ExPredTarget,
  output logic        Mispredict,
  output logic [31:0] RedirectPC,
  output logic [31:0] CtrlCount,
  output logic [31:0] MissCount
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [IDX-1:0]      f_idx;
  logic [IDX-1:0]      x_idx;
  logic [BP_TAG_W-1:0] f_tag;
  logic [BP_TAG_W-1:0] x_tag;
  bp_entry_t           f_ent;
  bp_entry_t           x_ent;
  logic                f_hit;
  logic                x_hit;
  logic                we;
  bp_entry_t           wr_ent;

  assign f_idx = IDX'(FetchPC >> 2);
  assign x_idx = IDX'(ExPC >> 2);
  assign f_tag = BP_TAG_W'(FetchPC >> (IDX + 2));
  assign x_tag = BP_TAG_W'(ExPC >> (IDX + 2));

  bpred_btb #(
    .ENTRIES (BHT_ENTRIES)
  ) u_btb (
    .clk     (Clk),
    .rst     (Rst),
    .rd0_idx (f_idx),
    .rd0_ent (f_ent),
    .rd1_idx (x_idx),
    .rd1_ent (x_ent),
    .we      (we),
    .wr_idx  (x_idx),
    .wr_ent  (wr_ent)
  );

  assign f_hit = f_ent.valid && (f_ent.tag == f_tag);
  assign x_hit = x_ent.valid && (x_ent.tag == x_tag);

  assign PredTaken  = f_hit && (f_ent.uncond || f_ent.ctr[1]);
  assign PredTarget = PredTaken ? f_ent.target : FetchPC + 32'd4;

  always_comb begin
    Mispredict = 1'b0;
    RedirectPC = '0;
    if (ExValid) begin
      Mispredict = (ExJumpFlag != ExPredTaken) ||
                   (ExJumpFlag && ExPredTaken &&
                    (ExTarget != ExPredTarget));
      RedirectPC = ExJumpFlag ? ExTarget : ExPC + 32'd4;
    end
  end

  // Stale entry on a non-control instruction is invalidated by index.
  always_comb begin
    we     = 1'b0;
    wr_ent = x_ent;
    if (ExValid) begin
      unique case (1'b1)
        ExIsCtrl && ExJumpFlag: begin
          we            = 1'b1;
          wr_ent.valid  = 1'b1;
          wr_ent.tag    = x_tag;
          wr_ent.target = ExTarget;
          wr_ent.uncond = ExIsUncond;
          wr_ent.ctr    = x_hit ? bp_sat_inc(x_ent.ctr) : BP_WT;
        end
        ExIsCtrl && !ExJumpFlag && x_hit: begin
          we         = 1'b1;
          wr_ent.ctr = bp_sat_dec(x_ent.ctr);
        end
        !ExIsCtrl && ExPredTaken: begin
          we           = 1'b1;
          wr_ent.valid = 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    ctrl_cnt_d = ctrl_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (ExValid && ExIsCtrl) ctrl_cnt_d = ctrl_cnt_q + 32'd1;
    if (Mispredict)          miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ctrl_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      ctrl_cnt_q <= ctrl_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign CtrlCount = ctrl_cnt_q;
  assign MissCount = miss_cnt_q;
`else
  assign CtrlCount = '0;
  assign MissCount = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor.
// Build with +define+BPRED_STATS_EN to check the statistics counters.
module tb_branch_predictor;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] FetchPC;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        ExValid;
  logic        ExIsCtrl;
  logic        ExIsUncond;
  logic [31:0] ExPC;
  logic        ExJumpFlag;
  logic [31:0] ExTarget;
  logic        ExPredTaken;
  logic [31:0] ExPredTarget;
  logic        Mispredict;
  logic [31:0] RedirectPC;
  logic [31:0] CtrlCount;
  logic [31:0] MissCount;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  branch_predictor dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .FetchPC      (FetchPC),
    .PredTaken    (PredTaken),
    .PredTarget   (PredTarget),
    .ExValid      (ExValid),
    .ExIsCtrl     (ExIsCtrl),
    .ExIsUncond   (ExIsUncond),
    .ExPC         (ExPC),
    .ExJumpFlag   (ExJumpFlag),
    .ExTarget     (ExTarget),
    .ExPredTaken  (ExPredTaken),
    .ExPredTarget (ExPredTarget),
    .Mispredict   (Mispredict),
    .RedirectPC   (RedirectPC),
    .CtrlCount    (CtrlCount),
    .MissCount    (MissCount)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ex_set(input logic ctrl, input logic unc,
                        input logic [31:0] pc, input logic jf,
                        input logic [31:0] tgt, input logic pt,
                        input logic [31:0] ptgt);
    ExValid      = 1'b1;
    ExIsCtrl     = ctrl;
    ExIsUncond   = unc;
    ExPC         = pc;
    ExJumpFlag   = jf;
    ExTarget     = tgt;
    ExPredTaken  = pt;
    ExPredTarget = ptgt;
    #1;
  endtask

  task automatic ex_clear();
    ExValid      = 1'b0;
    ExIsCtrl     = 1'b0;
    ExIsUncond   = 1'b0;
    ExPC         = '0;
    ExJumpFlag   = 1'b0;
    ExTarget     = '0;
    ExPredTaken  = 1'b0;
    ExPredTarget = '0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    ex_clear();
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tg);
    FetchPC = pc;
    #1;
    check({tag, ".tk"}, 32'(PredTaken), 32'(tk));
    check({tag, ".tg"}, PredTarget, tg);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;
  endtask

  logic stats;

  initial begin
`ifdef BPRED_STATS_EN
    stats = 1'b1;
`else
    stats = 1'b0;
`endif
    ex_clear();
    FetchPC = '0;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;

    look("rst_lookup", 32'h100, 1'b0, 32'h104);
    check("rst_misp", 32'(Mispredict), 0);
    check("rst_redir", RedirectPC, 0);
    check("rst_ctrl", CtrlCount, 0);
    check("rst_miss", MissCount, 0);

    // BEQ @0x100 taken, predicted not-taken
    ex_set(1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    check("beq_t.misp", 32'(Mispredict), 1);
    check("beq_t.redir", RedirectPC, 32'h80);
    tick();
    look("beq_t.look", 32'h100, 1'b1, 32'h80);

    // same BEQ not-taken; lookup sees pre-edge contents
    ex_set(1, 0, 32'h100, 0, 32'h80, 1, 32'h80);
    check("beq_nt.misp", 32'(Mispredict), 1);
    check("beq_nt.redir", RedirectPC, 32'h104);
    look("beq_nt.nobyp", 32'h100, 1'b1, 32'h80);
    tick();
    look("beq_nt.look", 32'h100, 1'b0, 32'h104);

    // bubble with mispredict-like operands is ignored
    ExJumpFlag = 1'b1;
    ExTarget   = 32'h1234;
    #1;
    check("bubble.misp", 32'(Mispredict), 0);
    check("bubble.redir", RedirectPC, 0);
    ex_clear();

    // JALR @0x200 trained to 0x400, evicts 0x100 at index 0
    ex_set(1, 1, 32'h200, 1, 32'h400, 0, 32'h204);
    check("jalr1.misp", 32'(Mispredict), 1);
    tick();
    look("jalr1.look", 32'h200, 1'b1, 32'h400);
    look("alias.look", 32'h100, 1'b0, 32'h104);

    // JALR target change
    ex_set(1, 1, 32'h200, 1, 32'h500, 1, 32'h400);
    check("jalr2.misp", 32'(Mispredict), 1);
    check("jalr2.redir", RedirectPC, 32'h500);
    tick();
    look("jalr2.look", 32'h200, 1'b1, 32'h500);

    // correct prediction
    ex_set(1, 1, 32'h200, 1, 32'h500, 1, 32'h500);
    check("jalr3.misp", 32'(Mispredict), 0);
    check("jalr3.redir", RedirectPC, 32'h500);
    tick();

    // stale entry hit by a non-control instruction
    ex_set(0, 0, 32'h200, 0, 32'h0, 1, 32'h500);
    check("stale.misp", 32'(Mispredict), 1);
    check("stale.redir", RedirectPC, 32'h204);
    tick();
    look("stale.look", 32'h200, 1'b0, 32'h204);

    // PC+4 wraps
    look("wrap.look", 32'hFFFF_FFFC, 1'b0, 32'h0);
    ex_set(0, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0);
    check("wrap.misp", 32'(Mispredict), 0);
    check("wrap.redir", RedirectPC, 32'h0);
    tick();

    // retrain then asynchronous reset pulse mid-cycle
    ex_set(1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    tick();
    look("pre_rst.look", 32'h100, 1'b1, 32'h80);
    #2;
    Rst = 1'b1;
    #1;
    look("async_rst.look", 32'h100, 1'b0, 32'h104);
    check("async_rst.ctrl", CtrlCount, 0);
    check("async_rst.miss", MissCount, 0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;

    // update presented in the reset cycle is dropped
    ex_set(1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    ex_clear();
    Rst = 1'b0;
    #1;
    look("rst_drop.look", 32'h100, 1'b0, 32'h104);

    // statistics: 3 control resolutions, 2 mispredicts
    do_reset();
    ex_set(1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    tick();
    ex_set(1, 0, 32'h100, 1, 32'h80, 1, 32'h80);
    tick();
    ex_set(0, 0, 32'h104, 0, 32'h0, 0, 32'h108);
    tick();
    ex_set(1, 0, 32'h300, 1, 32'h40, 0, 32'h304);
    tick();
    check("stats.ctrl", CtrlCount, stats ? 32'd3 : 32'd0);
    check("stats.miss", MissCount, stats ? 32'd2 : 32'd0);
    look("stats.look", 32'h300, 1'b1, 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
